// File: rtl/snake_mover.sv
// snake_mover: snake body engine feeding the game-state FSM.
// Holds head/body cells on the grid and steps one cell per move_tick.
// Ports:
//   clk, reset               clock, async active-high reset
//   game_state[2:0]          0 Init,1 Basic,2 Invincible,3 Dead,4 Win
//   move_tick                one-cycle step strobe
//   dir_valid, dir_req[1:0]  direction request (0 up,1 right,2 down,3 left)
//   fruit/ifruit/poison/barrier _x,_y,_valid   item cells
//   rd_idx -> rd_x, rd_y, rd_valid             segment read port
//   head_x, head_y, length   current head and length
//   Touch*, fruit_eaten      one-cycle event pulses
//   Long_enough, countDown   win level, invincibility ticks left
module snake_mover #(
   parameter int GRID_W    = 8,
   parameter int GRID_H    = 8,
   parameter int MAX_LEN   = 16,
   parameter int WIN_LEN   = 10,
   parameter int INV_TICKS = 5,
   parameter int START_X   = 3,
   parameter int START_Y   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] game_state,
   input  logic       move_tick,
   input  logic       dir_valid,
   input  logic [1:0] dir_req,
   input  logic [2:0] fruit_x,
   input  logic [2:0] fruit_y,
   input  logic       fruit_valid,
   input  logic [2:0] ifruit_x,
   input  logic [2:0] ifruit_y,
   input  logic       ifruit_valid,
   input  logic [2:0] poison_x,
   input  logic [2:0] poison_y,
   input  logic       poison_valid,
   input  logic [2:0] barrier_x,
   input  logic [2:0] barrier_y,
   input  logic       barrier_valid,
   input  logic [3:0] rd_idx,
   output logic [2:0] rd_x,
   output logic [2:0] rd_y,
   output logic       rd_valid,
   output logic [2:0] head_x,
   output logic [2:0] head_y,
   output logic [4:0] length,
   output logic       TouchEdge,
   output logic       TouchSelf,
   output logic       TouchPoison,
   output logic       Touchbarrier,
   output logic       Touch_I_Fruit,
   output logic       fruit_eaten,
   output logic       Long_enough,
   output logic [2:0] countDown
);

   localparam logic [3:0] GW   = 4'(GRID_W);
   localparam logic [3:0] GH   = 4'(GRID_H);
   localparam logic [4:0] MAXL = 5'(MAX_LEN);
   localparam logic [4:0] WINL = 5'(WIN_LEN);
   localparam logic [2:0] INV  = 3'(INV_TICKS);
   localparam logic [2:0] SX   = 3'(START_X);
   localparam logic [2:0] SY   = 3'(START_Y);
   localparam logic [1:0] RIGHT = 2'd1;

   logic [2:0] seg_x [MAX_LEN];
   logic [2:0] seg_y [MAX_LEN];
   logic [4:0] len;
   logic [1:0] dir;
   logic [1:0] pend;
   logic [2:0] cd;
   logic       p_edge, p_self, p_poison;
   logic       p_barrier, p_ifruit, p_fruit;

   // Next head from the registered head and the pending direction.
   // 4-bit math so that 0-1 wraps to 15 and lands outside the grid.
   logic [3:0] nx, ny;
   logic       off;

   always_comb begin
      nx = {1'b0, seg_x[0]};
      ny = {1'b0, seg_y[0]};
      unique case (pend)
         2'd0:    ny = ny - 4'd1;
         2'd1:    nx = nx + 4'd1;
         2'd2:    ny = ny + 4'd1;
         default: nx = nx - 4'd1;
      endcase
      off = (nx >= GW) || (ny >= GH);
   end

   logic grow, hit_i, hit_p, hit_b;

   assign grow  = fruit_valid && nx[2:0] == fruit_x
                  && ny[2:0] == fruit_y;
   assign hit_i = ifruit_valid && nx[2:0] == ifruit_x
                  && ny[2:0] == ifruit_y;
   assign hit_p = poison_valid && nx[2:0] == poison_x
                  && ny[2:0] == poison_y;
   assign hit_b = barrier_valid && nx[2:0] == barrier_x
                  && ny[2:0] == barrier_y;

   // The tail cell vacates on a plain move, so it only counts
   // as a collision when the snake grows this step.
   logic [4:0] lim;
   logic       self_hit;

   assign lim = grow ? len : len - 5'd1;

   always_comb begin
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (5'(i) < lim && seg_x[i] == nx[2:0]
             && seg_y[i] == ny[2:0])
            self_hit = 1'b1;
      end
   end

   // Requests are screened against the direction in force after
   // this cycle: the pending one if a tick applies it now.
   logic [1:0] ref_dir;
   logic       dir_ok;
   logic       active;

   assign ref_dir = move_tick ? pend : dir;
   assign dir_ok  = dir_valid && (dir_req != (ref_dir ^ 2'd2));
   assign active  = (game_state == 3'd1) || (game_state == 3'd2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= 3'd0;
            seg_y[i] <= 3'd0;
         end
         seg_x[0] <= SX;
         seg_y[0] <= SY;
         seg_x[1] <= SX - 3'd1;
         seg_y[1] <= SY;
         seg_x[2] <= SX - 3'd2;
         seg_y[2] <= SY;
         len       <= 5'd3;
         dir       <= RIGHT;
         pend      <= RIGHT;
         cd        <= 3'd0;
         p_edge    <= 1'b0;
         p_self    <= 1'b0;
         p_poison  <= 1'b0;
         p_barrier <= 1'b0;
         p_ifruit  <= 1'b0;
         p_fruit   <= 1'b0;
      end else begin
         p_edge    <= 1'b0;
         p_self    <= 1'b0;
         p_poison  <= 1'b0;
         p_barrier <= 1'b0;
         p_ifruit  <= 1'b0;
         p_fruit   <= 1'b0;
         if (game_state == 3'd0) begin
            for (int i = 0; i < MAX_LEN; i++) begin
               seg_x[i] <= 3'd0;
               seg_y[i] <= 3'd0;
            end
            seg_x[0] <= SX;
            seg_y[0] <= SY;
            seg_x[1] <= SX - 3'd1;
            seg_y[1] <= SY;
            seg_x[2] <= SX - 3'd2;
            seg_y[2] <= SY;
            len  <= 5'd3;
            dir  <= RIGHT;
            pend <= RIGHT;
            cd   <= 3'd0;
         end else if (active) begin
            if (dir_ok)
               pend <= dir_req;
            if (move_tick) begin
               dir <= pend;
               if (off) begin
                  p_edge <= 1'b1;
               end else begin
                  for (int i = MAX_LEN - 1; i > 0; i--) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0]  <= nx[2:0];
                  seg_y[0]  <= ny[2:0];
                  p_fruit   <= grow;
                  p_self    <= self_hit;
                  p_poison  <= hit_p;
                  p_barrier <= hit_b;
                  p_ifruit  <= hit_i;
                  if (grow && len < MAXL)
                     len <= len + 5'd1;
               end
               if (!off && hit_i)
                  cd <= INV;
               else if (game_state == 3'd2 && cd != 3'd0)
                  cd <= cd - 3'd1;
            end
         end
      end
   end

   assign head_x        = seg_x[0];
   assign head_y        = seg_y[0];
   assign length        = len;
   assign rd_x          = seg_x[rd_idx];
   assign rd_y          = seg_y[rd_idx];
   assign rd_valid      = {1'b0, rd_idx} < len;
   assign Long_enough   = len >= WINL;
   assign countDown     = cd;
   assign TouchEdge     = p_edge;
   assign TouchSelf     = p_self;
   assign TouchPoison   = p_poison;
   assign Touchbarrier  = p_barrier;
   assign Touch_I_Fruit = p_ifruit;
   assign fruit_eaten   = p_fruit;

endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: directed vector table plus randomized run against a
// queue-based model of the snake body.
module tb_snake_mover;

   localparam int MAXL = 16;
   localparam int WINL = 10;
   localparam int INV  = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] game_state;
   logic       move_tick, dir_valid;
   logic [1:0] dir_req;
   logic [2:0] fruit_x, fruit_y, ifruit_x, ifruit_y;
   logic [2:0] poison_x, poison_y, barrier_x, barrier_y;
   logic       fruit_valid, ifruit_valid, poison_valid, barrier_valid;
   logic [3:0] rd_idx;
   logic [2:0] rd_x, rd_y, head_x, head_y, countDown;
   logic       rd_valid, Long_enough;
   logic [4:0] length;
   logic       TouchEdge, TouchSelf, TouchPoison, Touchbarrier;
   logic       Touch_I_Fruit, fruit_eaten;

   always #5 clk = ~clk;

   snake_mover dut (
      .clk(clk), .reset(reset), .game_state(game_state),
      .move_tick(move_tick), .dir_valid(dir_valid), .dir_req(dir_req),
      .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_valid(fruit_valid),
      .ifruit_x(ifruit_x), .ifruit_y(ifruit_y),
      .ifruit_valid(ifruit_valid),
      .poison_x(poison_x), .poison_y(poison_y),
      .poison_valid(poison_valid),
      .barrier_x(barrier_x), .barrier_y(barrier_y),
      .barrier_valid(barrier_valid),
      .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
      .head_x(head_x), .head_y(head_y), .length(length),
      .TouchEdge(TouchEdge), .TouchSelf(TouchSelf),
      .TouchPoison(TouchPoison), .Touchbarrier(Touchbarrier),
      .Touch_I_Fruit(Touch_I_Fruit), .fruit_eaten(fruit_eaten),
      .Long_enough(Long_enough), .countDown(countDown)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: body kept as a queue of cells, head at index 0.
   int qx[$], qy[$];
   int mdir, mpend, mcd, mfl;

   function automatic void m_reset();
      qx = {3, 2, 1};
      qy = {3, 3, 3};
      mdir = 1; mpend = 1; mcd = 0; mfl = 0;
   endfunction

   function automatic void m_next(output int x, output int y);
      x = qx[0]; y = qy[0];
      case (mpend)
         0: y = y - 1;
         1: x = x + 1;
         2: y = y + 1;
         default: x = x - 1;
      endcase
   endfunction

   function automatic bit at(bit v, int x, int y, int cx, int cy);
      return v && x == cx && y == cy;
   endfunction

   function automatic void m_clk();
      int nx, ny, lim, opend, rdir;
      bit grow;
      mfl = 0;
      if (reset || game_state == 0) begin
         m_reset();
         return;
      end
      if (game_state != 1 && game_state != 2) return;
      opend = mpend;
      rdir = move_tick ? opend : mdir;
      if (move_tick) begin
         m_next(nx, ny);
         mdir = opend;
         if (nx < 0 || nx > 7 || ny < 0 || ny > 7) begin
            mfl = 32;
         end else begin
            grow = at(fruit_valid, nx, ny, fruit_x, fruit_y);
            lim = grow ? qx.size() : qx.size() - 1;
            for (int k = 0; k < lim; k++)
               if (qx[k] == nx && qy[k] == ny) mfl |= 16;
            if (at(poison_valid, nx, ny, poison_x, poison_y)) mfl |= 8;
            if (at(barrier_valid, nx, ny, barrier_x, barrier_y)) mfl |= 4;
            if (at(ifruit_valid, nx, ny, ifruit_x, ifruit_y)) mfl |= 2;
            if (grow) mfl |= 1;
            qx.push_front(nx);
            qy.push_front(ny);
            if (!grow || qx.size() > MAXL) begin
               void'(qx.pop_back());
               void'(qy.pop_back());
            end
         end
         if ((mfl & 2) != 0) mcd = INV;
         else if (game_state == 2 && mcd > 0) mcd = mcd - 1;
      end
      if (dir_valid && int'(dir_req) != (rdir + 2) % 4)
         mpend = int'(dir_req);
   endfunction

   function automatic int flags6();
      return int'({TouchEdge, TouchSelf, TouchPoison, Touchbarrier,
                   Touch_I_Fruit, fruit_eaten});
   endfunction

   task automatic cmp_model();
      chk("model head_x", int'(head_x), qx[0]);
      chk("model head_y", int'(head_y), qy[0]);
      chk("model length", int'(length), qx.size());
      chk("model flags", flags6(), mfl);
      chk("model Long_enough", int'(Long_enough), int'(qx.size() >= WINL));
      chk("model countDown", int'(countDown), mcd);
      chk("model rd_valid", int'(rd_valid), int'(int'(rd_idx) < qx.size()));
      if (int'(rd_idx) < qx.size()) begin
         chk("model rd_x", int'(rd_x), qx[rd_idx]);
         chk("model rd_y", int'(rd_y), qy[rd_idx]);
      end
   endtask

   task automatic step(bit rst);
      if (rst) begin
         reset = 1'b1;
         m_reset();
         @(posedge clk);
         #1;
         reset = 1'b0;
      end else begin
         m_clk();
         @(posedge clk);
         #1;
      end
      cmp_model();
   endtask

   typedef struct {
      bit rst; int gs; bit tk; int dr;
      int f; int i; int p; int b;
      int ri; int exy; int len; logic [6:0] fl; int cd; int rxy;
   } vec_t;

   function automatic vec_t V(bit rst, int gs, bit tk, int dr,
                              int f, int i, int p, int b, int ri,
                              int exy, int len, logic [6:0] fl,
                              int cd, int rxy);
      vec_t v;
      v.rst = rst; v.gs = gs; v.tk = tk; v.dr = dr;
      v.f = f; v.i = i; v.p = p; v.b = b; v.ri = ri;
      v.exy = exy; v.len = len; v.fl = fl; v.cd = cd; v.rxy = rxy;
      return v;
   endfunction

   vec_t vecs[$];

   function automatic void pick(output logic [2:0] cx,
                                output logic [2:0] cy, output logic v,
                                input int pv);
      int x, y;
      m_next(x, y);
      v = ($urandom_range(0, 99) < pv);
      if ($urandom_range(0, 2) == 0 && x >= 0 && x < 8
          && y >= 0 && y < 8) begin
         cx = 3'(x); cy = 3'(y);
      end else begin
         cx = 3'($urandom_range(0, 7));
         cy = 3'($urandom_range(0, 7));
      end
   endfunction

   initial begin
      reset = 1'b1; game_state = 3'd0; move_tick = 1'b0;
      dir_valid = 1'b0; dir_req = 2'd0; rd_idx = 4'd0;
      fruit_x = 3'd0; fruit_y = 3'd0; fruit_valid = 1'b0;
      ifruit_x = 3'd0; ifruit_y = 3'd0; ifruit_valid = 1'b0;
      poison_x = 3'd0; poison_y = 3'd0; poison_valid = 1'b0;
      barrier_x = 3'd0; barrier_y = 3'd0; barrier_valid = 1'b0;
      m_reset();
      #12;

      // rst gs tk dr f i p b ri exy len flags cd rxy
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,2,33,3,7'b0000000,0,13));
      vecs.push_back(V(0,0,1,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,0,1,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,0,1,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,0, 0,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,1,32,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,2,31,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,2,30,3,7'b0000000,0,32));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,2,30,3,7'b0100000,0,32));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,0, 1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,0, 3,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,1,43,3,7'b0000000,0,33));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,43,-1,-1,-1,3,43,4,7'b0000001,0,13));
      vecs.push_back(V(0,1,1,-1,53,-1,-1,-1,4,53,5,7'b0000001,0,13));
      vecs.push_back(V(0,1,1,-1,63,-1,-1,-1,5,63,6,7'b0000001,0,13));
      vecs.push_back(V(0,1,1,-1,73,-1,-1,-1,6,73,7,7'b0000001,0,13));
      vecs.push_back(V(0,1,0, 2,-1,-1,-1,-1,0,73,7,7'b0000000,0,73));
      vecs.push_back(V(0,1,1,-1,74,-1,-1,-1,7,74,8,7'b0000001,0,13));
      vecs.push_back(V(0,1,1,-1,75,-1,-1,-1,8,75,9,7'b0000001,0,13));
      vecs.push_back(V(0,1,1,-1,76,-1,-1,-1,9,76,10,7'b1000001,0,13));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,9,77,10,7'b1000000,0,23));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,10,77,10,7'b1100000,0,-1));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,-1,43,-1,-1,0,43,3,7'b0000010,5,43));
      vecs.push_back(V(0,2,1,-1,-1,-1,-1,-1,0,53,3,7'b0000000,4,53));
      vecs.push_back(V(0,2,1,-1,-1,-1,-1,-1,0,63,3,7'b0000000,3,63));
      vecs.push_back(V(0,2,1,-1,-1,-1,-1,-1,0,73,3,7'b0000000,2,73));
      vecs.push_back(V(0,2,0, 2,-1,-1,-1,-1,0,73,3,7'b0000000,2,73));
      vecs.push_back(V(0,2,1,-1,-1,-1,-1,-1,0,74,3,7'b0000000,1,74));
      vecs.push_back(V(0,2,1,-1,-1,-1,-1,-1,0,75,3,7'b0000000,0,75));
      vecs.push_back(V(0,2,1,-1,-1,-1,-1,-1,0,76,3,7'b0000000,0,76));
      vecs.push_back(V(0,1,1,-1,-1,-1,77,77,0,77,3,7'b0001100,0,77));
      vecs.push_back(V(0,3,1,-1,-1,-1,-1,-1,1,77,3,7'b0000000,0,76));
      vecs.push_back(V(0,4,1,-1,-1,-1,-1,-1,1,77,3,7'b0000000,0,76));
      vecs.push_back(V(0,3,0, 0,-1,-1,-1,-1,0,77,3,7'b0000000,0,77));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,0,77,3,7'b0100000,0,77));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,43,43,-1,-1,0,43,4,7'b0000011,5,43));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,43,-1,-1,-1,0,43,4,7'b0000001,0,43));
      vecs.push_back(V(0,1,1,-1,53,-1,-1,-1,0,53,5,7'b0000001,0,53));
      vecs.push_back(V(0,1,0, 0,-1,-1,-1,-1,0,53,5,7'b0000000,0,53));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,0,52,5,7'b0000000,0,52));
      vecs.push_back(V(0,1,0, 3,-1,-1,-1,-1,0,52,5,7'b0000000,0,52));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,0,42,5,7'b0000000,0,42));
      vecs.push_back(V(0,1,0, 2,-1,-1,-1,-1,0,42,5,7'b0000000,0,42));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,3,43,5,7'b0010000,0,53));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,43,-1,-1,-1,0,43,4,7'b0000001,0,43));
      vecs.push_back(V(0,1,0, 0,-1,-1,-1,-1,0,43,4,7'b0000000,0,43));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,0,42,4,7'b0000000,0,42));
      vecs.push_back(V(0,1,0, 3,-1,-1,-1,-1,0,42,4,7'b0000000,0,42));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,0,32,4,7'b0000000,0,32));
      vecs.push_back(V(0,1,0, 2,-1,-1,-1,-1,0,32,4,7'b0000000,0,32));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,3,33,4,7'b0000000,0,43));
      vecs.push_back(V(0,1,0, 3,-1,-1,-1,-1,0,33,4,7'b0000000,0,33));
      vecs.push_back(V(1,0,0,-1,-1,-1,-1,-1,0,33,3,7'b0000000,0,33));
      vecs.push_back(V(0,1,1,-1,-1,-1,-1,-1,0,43,3,7'b0000000,0,43));

      foreach (vecs[n]) begin
         vec_t v;
         v = vecs[n];
         game_state = 3'(v.gs);
         move_tick = v.tk;
         dir_valid = (v.dr >= 0);
         dir_req = (v.dr >= 0) ? 2'(v.dr) : 2'd0;
         fruit_valid = (v.f >= 0);
         fruit_x = 3'(v.f / 10); fruit_y = 3'(v.f % 10);
         ifruit_valid = (v.i >= 0);
         ifruit_x = 3'(v.i / 10); ifruit_y = 3'(v.i % 10);
         poison_valid = (v.p >= 0);
         poison_x = 3'(v.p / 10); poison_y = 3'(v.p % 10);
         barrier_valid = (v.b >= 0);
         barrier_x = 3'(v.b / 10); barrier_y = 3'(v.b % 10);
         rd_idx = 4'(v.ri);
         step(v.rst);
         chk($sformatf("vec%0d head", n),
             int'(head_x) * 10 + int'(head_y), v.exy);
         chk($sformatf("vec%0d length", n), int'(length), v.len);
         chk($sformatf("vec%0d flags", n),
             int'({Long_enough, TouchEdge, TouchSelf, TouchPoison,
                   Touchbarrier, Touch_I_Fruit, fruit_eaten}),
             int'(v.fl));
         chk($sformatf("vec%0d countDown", n), int'(countDown), v.cd);
         if (v.rxy < 0)
            chk($sformatf("vec%0d rd_valid", n), int'(rd_valid), 0);
         else
            chk($sformatf("vec%0d rd", n),
                int'(rd_valid) * 100 + int'(rd_x) * 10 + int'(rd_y),
                100 + v.rxy);
      end

      for (int n = 0; n < 3000; n++) begin
         int g;
         bit rst;
         rst = ($urandom_range(0, 199) == 0);
         g = $urandom_range(0, 39);
         if (g == 0) game_state = 3'd0;
         else if (g == 1) game_state = 3'd3;
         else if (g == 2) game_state = 3'd4;
         else if (g < 24) game_state = 3'd1;
         else game_state = 3'd2;
         move_tick = $urandom_range(0, 1);
         dir_valid = !move_tick && ($urandom_range(0, 2) == 0);
         dir_req = 2'($urandom_range(0, 3));
         pick(fruit_x, fruit_y, fruit_valid, 80);
         pick(ifruit_x, ifruit_y, ifruit_valid, 30);
         pick(poison_x, poison_y, poison_valid, 40);
         pick(barrier_x, barrier_y, barrier_valid, 40);
         rd_idx = 4'($urandom_range(0, 15));
         step(rst);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
